// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller and its APB master: register map,
// source count and the master FSM state encoding.
package irq_pkg;

  localparam int unsigned NumSrc = 4;
  localparam int unsigned SrcW   = $clog2(NumSrc);
  localparam int unsigned ThrW   = 3;

  localparam logic [31:0] IrqClearAddr  = 32'd8;
  localparam logic [31:0] IrqThreshAddr = 32'd9;

  typedef enum logic [2:0] {
    StIdle,
    StHost,
    StSetup,
    StAccess,
    StHold
  } mst_state_e;

endpackage

// File: rtl/irq_apb_master_if.sv
// APB write-only bus between the interrupt master and the controller's slave port.
interface irq_apb_master_if;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr
  );

endinterface

// File: rtl/irq_apb_master_apb_write_engine.sv
// APB write engine: drives SETUP/ACCESS from the master FSM phase, bounds ACCESS with a
// timeout counter and keeps the sticky error flag.
module irq_apb_master_apb_write_engine #(
  parameter int unsigned Timeout = 16
) (
  input  logic             pclk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      data_i,
  input  logic             setup_i,
  input  logic             access_i,
  input  logic             err_clr_i,
  output logic             done_o,
  output logic             err_o,
  irq_apb_master_if.master apb
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, data_q;
  logic            err_q, err_d;
  logic            timeout;

  assign timeout = access_i && !apb.pready && (cnt_q == CntW'(Timeout - 1));
  assign done_o  = en_i && access_i && (apb.pready || timeout);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (en_i) begin
      if (done_o) begin
        cnt_d = '0;
      end else if (access_i) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (err_clr_i) err_d = 1'b0;
      // A new error wins over a clear in the same cycle.
      if (done_o && (timeout || apb.pslverr)) err_d = 1'b1;
    end
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (en_i && load_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign apb.psel    = setup_i || access_i;
  assign apb.penable = access_i;
  assign apb.pwrite  = setup_i || access_i;
  assign apb.paddr   = addr_q;
  assign apb.pwdata  = data_q;
  assign err_o       = err_q;

endmodule

// File: rtl/irq_apb_master.sv
// CPU-side APB master for the 4-source interrupt controller: captures the source vector,
// clears it after host service and forwards host priority-threshold writes.
module irq_apb_master
  import irq_pkg::*;
#(
  parameter logic [31:0] ClearAddr  = IrqClearAddr,
  parameter logic [31:0] ThreshAddr = IrqThreshAddr,
  parameter int unsigned Timeout    = 16,
  parameter int unsigned Holdoff    = 3
) (
  input  logic             pclk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  irq_apb_master_if.master apb,
  input  logic             interrupt_i,
  input  logic [SrcW-1:0]  irq_address_i,
  output logic             irq_valid_o,
  output logic [SrcW-1:0]  irq_vector_o,
  input  logic             irq_done_i,
  input  logic             thr_wr_i,
  input  logic [ThrW-1:0]  thr_data_i,
  output logic             thr_busy_o,
  output logic             err_o,
  input  logic             err_clr_i
);

  localparam int unsigned HoldW = (Holdoff > 1) ? $clog2(Holdoff) : 1;

  mst_state_e      state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic            thr_pend_q, thr_pend_d;
  logic [ThrW-1:0] thr_data_q, thr_data_d;
  logic            irq_valid_q, irq_valid_d;
  logic [SrcW-1:0] irq_vec_q, irq_vec_d;
  logic            is_clear_q, is_clear_d;
  logic            load, done, thr_req;
  logic [31:0]     addr, data;
  logic [ThrW-1:0] thr_val;

  // A request arriving in the same cycle counts as pending so it still beats an interrupt.
  assign thr_req = thr_pend_q || thr_wr_i;
  assign thr_val = thr_pend_q ? thr_data_q : thr_data_i;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    thr_pend_d  = thr_pend_q;
    thr_data_d  = thr_data_q;
    irq_valid_d = irq_valid_q;
    irq_vec_d   = irq_vec_q;
    is_clear_d  = is_clear_q;
    load        = 1'b0;
    addr        = ThreshAddr;
    data        = 32'(thr_val);
    if (enable_i) begin
      if (thr_wr_i && !thr_pend_q) begin
        thr_pend_d = 1'b1;
        thr_data_d = thr_data_i;
      end
      unique case (state_q)
        StIdle: begin
          if (thr_req) begin
            load       = 1'b1;
            is_clear_d = 1'b0;
            state_d    = StSetup;
          end else if (interrupt_i) begin
            irq_vec_d   = irq_address_i;
            irq_valid_d = 1'b1;
            state_d     = StHost;
          end
        end
        StHost: begin
          if (irq_done_i) begin
            irq_valid_d = 1'b0;
            load        = 1'b1;
            addr        = ClearAddr;
            data        = 32'd1 << irq_vec_q;
            is_clear_d  = 1'b1;
            state_d     = StSetup;
          end
        end
        StSetup: state_d = StAccess;
        StAccess: begin
          if (done) begin
            if (is_clear_q) begin
              hold_d  = '0;
              state_d = (Holdoff > 0) ? StHold : StIdle;
            end else begin
              thr_pend_d = 1'b0;
              state_d    = StIdle;
            end
          end
        end
        StHold: begin
          if (hold_q == HoldW'(Holdoff - 1)) begin
            state_d = StIdle;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      thr_pend_q  <= 1'b0;
      thr_data_q  <= '0;
      irq_valid_q <= 1'b0;
      irq_vec_q   <= '0;
      is_clear_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      thr_pend_q  <= thr_pend_d;
      thr_data_q  <= thr_data_d;
      irq_valid_q <= irq_valid_d;
      irq_vec_q   <= irq_vec_d;
      is_clear_q  <= is_clear_d;
    end
  end

  irq_apb_master_apb_write_engine #(
    .Timeout (Timeout)
  ) u_engine (
    .pclk_i    (pclk_i),
    .rst_n_i   (rst_n_i),
    .en_i      (enable_i),
    .load_i    (load),
    .addr_i    (addr),
    .data_i    (data),
    .setup_i   (state_q == StSetup),
    .access_i  (state_q == StAccess),
    .err_clr_i (err_clr_i),
    .done_o    (done),
    .err_o     (err_o),
    .apb       (apb)
  );

  assign irq_valid_o  = irq_valid_q;
  assign irq_vector_o = irq_vec_q;
  assign thr_busy_o   = thr_pend_q;

endmodule

// File: tb/tb_irq_apb_master.sv
// Self-checking bench for irq_apb_master: hand sequences, a vector table and random
// episodes scored against a transaction-level model of the bus writes and error flag.
module tb_irq_apb_master;
  import irq_pkg::*;

  localparam int unsigned Timeout = 16;
  localparam int unsigned Holdoff = 3;

  typedef struct {
    bit          is_thr;
    logic [2:0]  val;
    int          wait_n;
    bit          serr;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    int          e_acc;
    bit          e_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          setup_n;
    int          acc_n;
    bit          bad;
  } xfer_t;

  logic pclk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic interrupt = 1'b0, irq_done = 1'b0, thr_wr = 1'b0, err_clr = 1'b0;
  logic [SrcW-1:0] irq_address = '0;
  logic [2:0]      thr_data = '0;
  logic            irq_valid, thr_busy, err_flag;
  logic [SrcW-1:0] irq_vector;

  int checks = 0, failures = 0;
  int slv_wait = 0, slv_cnt = 0;
  bit slv_err = 1'b0, model_err = 1'b0;
  xfer_t xfers[$];
  xfer_t cur;
  bit    in_x = 1'b0;

  irq_apb_master_if apb ();

  irq_apb_master #(
    .Timeout (Timeout),
    .Holdoff (Holdoff)
  ) dut (
    .pclk_i        (pclk),
    .rst_n_i       (rst_n),
    .enable_i      (enable),
    .apb           (apb),
    .interrupt_i   (interrupt),
    .irq_address_i (irq_address),
    .irq_valid_o   (irq_valid),
    .irq_vector_o  (irq_vector),
    .irq_done_i    (irq_done),
    .thr_wr_i      (thr_wr),
    .thr_data_i    (thr_data),
    .thr_busy_o    (thr_busy),
    .err_o         (err_flag),
    .err_clr_i     (err_clr)
  );

  always #5 pclk = ~pclk;

  // Slave: ready after slv_wait ACCESS cycles.
  always @(negedge pclk) begin
    if (apb.psel && apb.penable) begin
      apb.pready  = (slv_cnt >= slv_wait);
      apb.pslverr = slv_err && (slv_cnt >= slv_wait);
      slv_cnt++;
    end else begin
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      slv_cnt     = 0;
    end
  end

  // Monitor: one record per transfer, flags address/data/pwrite instability.
  always @(negedge pclk) begin
    if (!rst_n) begin
      in_x = 1'b0;
    end else if (apb.psel) begin
      if (!in_x) begin
        in_x = 1'b1;
        cur.addr = apb.paddr;
        cur.data = apb.pwdata;
        cur.setup_n = 0;
        cur.acc_n = 0;
        cur.bad = 1'b0;
      end
      if (apb.paddr !== cur.addr || apb.pwdata !== cur.data || apb.pwrite !== 1'b1) cur.bad = 1'b1;
      if (apb.penable) cur.acc_n++;
      else cur.setup_n++;
    end else if (in_x) begin
      in_x = 1'b0;
      xfers.push_back(cur);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic wait_xfer(input string tag, output xfer_t x, output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (xfers.size() != 0) break;
      tick();
    end
    chk({tag, ".done"}, 32'(xfers.size() != 0), 32'd1);
    if (xfers.size() != 0) begin
      x   = xfers.pop_front();
      got = 1'b1;
    end
  endtask

  function automatic vec_t ref_model(input vec_t v, input bit prior);
    int unsigned src = 32'(v.val) % NumSrc;
    v.e_addr = v.is_thr ? 32'd9 : 32'd8;
    v.e_data = v.is_thr ? 32'(v.val) : 32'(2 ** src);
    v.e_acc  = (v.wait_n + 1 < Timeout) ? v.wait_n + 1 : Timeout;
    v.e_err  = prior || v.serr || (v.wait_n >= Timeout);
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    xfer_t x;
    bit    got;
    slv_wait = v.wait_n;
    slv_err  = v.serr;
    if (v.is_thr) begin
      thr_wr = 1'b1;
      thr_data = v.val;
      tick();
      thr_wr = 1'b0;
      chk({tag, ".busy"}, 32'(thr_busy), 32'd1);
    end else begin
      interrupt = 1'b1;
      irq_address = v.val[SrcW-1:0];
      for (int i = 0; i < 20 && !irq_valid; i++) tick();
      chk({tag, ".valid"}, 32'(irq_valid), 32'd1);
      chk({tag, ".vector"}, 32'(irq_vector), 32'(v.val[SrcW-1:0]));
      interrupt = 1'b0;
      irq_done = 1'b1;
      tick();
      irq_done = 1'b0;
      chk({tag, ".valid_drop"}, 32'(irq_valid), 32'd0);
    end
    wait_xfer(tag, x, got);
    if (got) begin
      chk({tag, ".paddr"}, x.addr, v.e_addr);
      chk({tag, ".pwdata"}, x.data, v.e_data);
      chk({tag, ".setup"}, 32'(x.setup_n), 32'd1);
      chk({tag, ".access"}, 32'(x.acc_n), 32'(v.e_acc));
      chk({tag, ".stable"}, 32'(x.bad), 32'd0);
    end
    chk({tag, ".err"}, 32'(err_flag), 32'(v.e_err));
    chk({tag, ".busy_end"}, 32'(thr_busy), 32'd0);
    repeat (Holdoff + 2) tick();
  endtask

  initial begin
    vec_t  tbl[8];
    xfer_t x;
    bit    got, ok;
    int    waits[10];

    // Table: is_thr, val, wait, slverr -> addr, data, access cycles, err
    tbl[0] = '{1'b0, 3'd2, 0,  1'b0, 32'd8, 32'h4, 1,  1'b0};
    tbl[1] = '{1'b0, 3'd0, 3,  1'b0, 32'd8, 32'h1, 4,  1'b0};
    tbl[2] = '{1'b0, 3'd3, 20, 1'b0, 32'd8, 32'h8, 16, 1'b1};
    tbl[3] = '{1'b0, 3'd1, 0,  1'b1, 32'd8, 32'h2, 1,  1'b1};
    tbl[4] = '{1'b1, 3'd3, 0,  1'b0, 32'd9, 32'h3, 1,  1'b0};
    tbl[5] = '{1'b1, 3'd7, 15, 1'b0, 32'd9, 32'h7, 16, 1'b0};
    tbl[6] = '{1'b1, 3'd5, 16, 1'b0, 32'd9, 32'h5, 16, 1'b1};
    tbl[7] = '{1'b1, 3'd0, 2,  1'b1, 32'd9, 32'h0, 3,  1'b1};
    waits = '{0, 1, 2, 3, 7, 14, 15, 16, 17, 25};

    // Reset values
    enable = 1'b1;
    repeat (3) tick();
    chk("rst.ctrl", 32'({apb.psel, apb.penable, apb.pwrite, irq_valid, thr_busy, err_flag,
                         irq_vector}), 32'd0);
    chk("rst.paddr", apb.paddr, 32'd0);
    chk("rst.pwdata", apb.pwdata, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.idle", 32'({apb.psel, irq_valid, thr_busy, err_flag}), 32'd0);

    // irq_done outside HOST does nothing
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    repeat (3) tick();
    chk("done_ignored", 32'(xfers.size()), 32'd0);

    // Capture, clear write timing, holdoff
    slv_wait = 0;
    slv_err = 1'b0;
    interrupt = 1'b1;
    irq_address = 2'd2;
    tick();
    chk("b.capture", 32'({irq_valid, irq_vector}), 32'b110);
    interrupt = 1'b0;
    tick();
    tick();
    chk("b.valid_held", 32'({irq_valid, apb.psel}), 32'b10);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    interrupt = 1'b1;
    irq_address = 2'd1;
    chk("b.setup", 32'({apb.psel, apb.penable, irq_valid}), 32'b100);
    tick();
    chk("b.access", 32'({apb.psel, apb.penable}), 32'b11);
    chk("b.paddr", apb.paddr, 32'd8);
    chk("b.pwdata", apb.pwdata, 32'h4);
    tick();
    ok = !apb.psel && !irq_valid;
    repeat (Holdoff) begin
      tick();
      if (irq_valid) ok = 1'b0;
    end
    chk("b.holdoff", 32'(ok), 32'd1);
    tick();
    chk("b.recapture", 32'({irq_valid, irq_vector}), 32'b101);
    wait_xfer("b.x1", x, got);
    if (got) chk("b.x1_len", 32'({x.setup_n[3:0], x.acc_n[3:0]}), 32'h11);
    interrupt = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    wait_xfer("b.x2", x, got);
    if (got) chk("b.x2_data", x.data, 32'h2);
    repeat (Holdoff + 2) tick();

    // Threshold and interrupt in the same IDLE cycle: threshold first
    interrupt = 1'b1;
    irq_address = 2'd3;
    thr_wr = 1'b1;
    thr_data = 3'd6;
    tick();
    thr_wr = 1'b0;
    chk("c.first", 32'({apb.psel, apb.penable, irq_valid, thr_busy}), 32'b1001);
    chk("c.paddr", apb.paddr, 32'd9);
    chk("c.pwdata", apb.pwdata, 32'h6);
    tick();
    tick();
    chk("c.busy_done", 32'({thr_busy, apb.psel}), 32'd0);
    tick();
    chk("c.then_irq", 32'({irq_valid, irq_vector}), 32'b111);
    interrupt = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    repeat (Holdoff + 4) tick();
    chk("c.two_xfers", 32'(xfers.size()), 32'd2);
    xfers.delete();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      pulse_err_clr();
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // enable low mid-ACCESS freezes bus and timeout counter
    pulse_err_clr();
    slv_wait = 1000;
    thr_wr = 1'b1;
    thr_data = 3'd5;
    tick();
    thr_wr = 1'b0;
    for (int i = 0; i < 10 && !(apb.psel && apb.penable); i++) tick();
    enable = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (!(apb.psel && apb.penable && apb.paddr == 32'd9 && thr_busy && !err_flag)) ok = 1'b0;
    end
    chk("d.frozen", 32'(ok), 32'd1);
    enable = 1'b1;
    wait_xfer("d", x, got);
    if (got) chk("d.access", 32'(x.acc_n), 32'(Timeout + 20));
    chk("d.err", 32'(err_flag), 32'd1);
    repeat (3) tick();

    // Error set beats a simultaneous clear
    err_clr = 1'b1;
    tick();
    chk("f.cleared", 32'(err_flag), 32'd0);
    thr_wr = 1'b1;
    thr_data = 3'd1;
    tick();
    thr_wr = 1'b0;
    for (int i = 0; i < 10 && !(apb.psel && apb.penable); i++) tick();
    for (int i = 0; i < 40 && apb.psel; i++) tick();
    chk("f.set_wins", 32'(err_flag), 32'd1);
    tick();
    err_clr = 1'b0;
    chk("f.clear_after", 32'(err_flag), 32'd0);
    repeat (3) tick();
    xfers.delete();

    // Random episodes against the reference model
    model_err = 1'b0;
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.is_thr = 1'($urandom_range(0, 1));
      v.val    = 3'($urandom_range(0, 7));
      v.wait_n = waits[$urandom_range(0, 9)];
      v.serr   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        pulse_err_clr();
        model_err = 1'b0;
      end
      v = ref_model(v, model_err);
      model_err = v.e_err;
      run_vec(v, $sformatf("rnd%0d", n));
    end

    // Reset during ACCESS
    slv_wait = 1000;
    thr_wr = 1'b1;
    thr_data = 3'd4;
    tick();
    thr_wr = 1'b0;
    for (int i = 0; i < 10 && !(apb.psel && apb.penable); i++) tick();
    chk("e.in_access", 32'(apb.penable), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("e.async", 32'({apb.psel, apb.penable}), 32'd0);
    chk("e.outs", 32'({apb.pwrite, irq_valid, thr_busy, err_flag, irq_vector}), 32'd0);
    chk("e.bus", apb.paddr | apb.pwdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      tick();
      if (apb.psel || thr_busy) ok = 1'b0;
    end
    chk("e.pending_lost", 32'(ok), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
